// File: rtl/parity_pkg.sv
// Shared definitions for the parity unit: parity modes, checker states and the
// mode-to-parity helper used by both the generator and the checker.
package parity_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_typ_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAccum   = 2'b01,
        StWaitPar = 2'b10,
        StDone    = 2'b11
    } chk_state_e;

    // xor_val is the XOR-reduction of the data bits.
    function automatic logic mode_parity(input par_typ_e mode, input logic xor_val);
        logic p;
        unique case (mode)
            PAR_EVEN:  p = xor_val;
            PAR_ODD:   p = ~xor_val;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/parity_unit_chk.sv
// Serial parity checker: accumulates DataWidth bits, then compares the trailing
// parity bit against the mode latched at frame start.
module par_chk
    import parity_pkg::*;
#(
    parameter int unsigned DataWidth = 8
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     start_i,
    input  logic     en_i,
    input  logic     bit_i,
    input  par_typ_e par_typ_i,
    output logic     busy_o,
    output logic     done_o,
    output logic     par_err_o
);

    localparam int unsigned CntW = $clog2(DataWidth + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(DataWidth - 1);

    chk_state_e      state_q, state_d;
    par_typ_e        mode_q, mode_d;
    logic            acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        // A start pulse opens (or restarts) a frame anywhere except DONE.
        if (start_i && state_q != StDone) begin
            mode_d  = par_typ_i;
            acc_d   = 1'b0;
            cnt_d   = '0;
            state_d = StAccum;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAccum: begin
                    if (en_i) begin
                        acc_d = acc_q ^ bit_i;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LastIdx) state_d = StWaitPar;
                    end
                end
                StWaitPar: begin
                    if (en_i) begin
                        err_d   = bit_i ^ mode_parity(mode_q, acc_q);
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            mode_q  <= PAR_EVEN;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign done_o    = (state_q == StDone);
    assign par_err_o = err_q;

endmodule

// File: rtl/parity_unit.sv
// Parity generator plus serial parity checker. Defining PARITY_ERR_CNT_EN adds
// a saturating err_cnt output counting failed checks.
module parity_unit
    import parity_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_valid,
    input  logic [1:0]            PAR_TYP,
    output logic                  par_bit,
    input  logic                  ser_start,
    input  logic                  ser_en,
    input  logic                  ser_bit,
    output logic                  busy,
    output logic                  chk_done,
    output logic                  par_err
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  err_cnt
`endif
);

    logic par_bit_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            par_bit_q <= 1'b0;
        end else if (Data_valid) begin
            par_bit_q <= mode_parity(par_typ_e'(PAR_TYP), ^P_DATA);
        end
    end

    assign par_bit = par_bit_q;

    par_chk #(
        .DataWidth(DATA_WIDTH)
    ) u_chk (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .start_i  (ser_start),
        .en_i     (ser_en),
        .bit_i    (ser_bit),
        .par_typ_i(par_typ_e'(PAR_TYP)),
        .busy_o   (busy),
        .done_o   (chk_done),
        .par_err_o(par_err)
    );

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            err_cnt_q <= '0;
        end else if (chk_done && par_err && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
